// File: rtl/sub16_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding and nibble width.
package sub16_nibble_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub16_nibble_seq_sub4_bin.sv
// Combinational 4-bit subtractor with borrow: diff = x - y - bin, bout set on underflow.
import sub16_nibble_seq_pkg::*;

module sub4_bin (
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);

  logic [NIBBLE_W:0] full;

  // One extra bit catches the sign of the result, which is exactly the borrow-out.
  assign full = {1'b0, x} - {1'b0, y} - (NIBBLE_W + 1)'(bin);
  assign diff = full[NIBBLE_W-1:0];
  assign bout = full[NIBBLE_W];

endmodule

// File: rtl/sub16_nibble_seq.sv
// Nibble-serial unsigned subtractor: one 4-bit slice per cycle, LSB first, valid/ready on both sides.
import sub16_nibble_seq_pkg::*;

module sub16_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  A,
  input  logic [NIBBLE_W*NIBBLES-1:0]  B,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  D,
  output logic                         Bout
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, b_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 borrow_q;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, nib_diff;
  logic                 nib_bout;
  logic                 accept, last;

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign last   = (idx_q == IDX_W'(NIBBLES - 1));
  assign Bout   = borrow_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values, matching hardware.
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a new accept needs a fresh cycle.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Nibble select for the shared slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  sub4_bin u_sub4 (
    .x    (a_nib),
    .y    (b_nib),
    .bin  (borrow_q),
    .diff (nib_diff),
    .bout (nib_bout)
  );

  // Datapath: operands are captured only on the accept edge, so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      D        <= '0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      idx_q    <= '0;
      borrow_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) D[i*NIBBLE_W +: NIBBLE_W] <= nib_diff;
      end
      borrow_q <= nib_bout;
      idx_q    <= last ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub16_nibble_seq.sv
// Self-checking bench: directed vector table, backpressure/reset sequences, random stream vs arithmetic model.
module tb_sub16_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;

  int vectors    = 0;
  int miscompares = 0;

  sub16_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .Bout      (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic on the whole operand.
  function automatic logic [W-1:0] model_d(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned diff;
    diff = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return W'(diff);
  endfunction

  function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  // One full transaction. Inputs change #1 after rising edges; outputs sampled there too.
  task automatic txn(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input logic [W-1:0] exp_d, input logic exp_bout,
                     input int stall, input bit poke_busy);
    int n;
    int lat;
    logic [W-1:0] held_d;
    logic         held_b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, " in_ready_wait"}, 32'(in_ready), 32'd1);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (poke_busy) begin
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(NIB + 1));
    check({name, " D"}, 32'(d), 32'(exp_d));
    check({name, " Bout"}, 32'(bout), 32'(exp_bout));
    held_d = d; held_b = bout;
    for (int i = 0; i < stall; i++) begin
      in_valid = poke_busy;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      if (poke_busy) begin
        check({name, " stall in_ready"}, 32'(in_ready), 32'd0);
        check({name, " stall out_valid"}, 32'(out_valid), 32'd1);
        check({name, " stall D"}, 32'(d), 32'(held_d));
        check({name, " stall Bout"}, 32'(bout), 32'(held_b));
      end
    end
    // Release: with poke_busy, in_valid stays high across the DONE->IDLE edge and must not be taken.
    in_valid = poke_busy;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " release out_valid"}, 32'(out_valid), 32'd0);
    check({name, " release in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  vec_t table_v[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

    table_v.push_back('{16'h0003, 16'h0005, 16'hFFFE, 1'b1});
    table_v.push_back('{16'h000F, 16'h000A, 16'h0005, 1'b0});
    table_v.push_back('{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0});
    table_v.push_back('{16'h1000, 16'h0001, 16'h0FFF, 1'b0});
    table_v.push_back('{16'h0000, 16'h0001, 16'hFFFF, 1'b1});
    table_v.push_back('{16'h8000, 16'h7FFF, 16'h0001, 1'b0});
    table_v.push_back('{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1});
    table_v.push_back('{16'hABCD, 16'h0000, 16'hABCD, 1'b0});

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset D", 32'(d), 32'd0);
    check("reset Bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (table_v[i]) begin
      txn($sformatf("vec%0d", i), table_v[i].a, table_v[i].b,
          table_v[i].exp_d, table_v[i].exp_bout, 0, 1'b0);
    end

    // Backpressure: 10 stalled cycles in DONE while other operands are offered.
    txn("backpressure", 16'h4321, 16'h1234, 16'h30ED, 1'b0, 10, 1'b1);

    // Reset in RUN at idx=2: leaves no partial result, then the next pair completes normally.
    a = 16'hFFFF; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort D", 32'(d), 32'd0);
    check("abort Bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn("after_abort", 16'h1234, 16'h0234, 16'h1000, 1'b0, 0, 1'b0);

    // Random stream with random idle gaps and output stalls.
    for (int t = 0; t < 150; t++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (t % 10 == 0) ? ra : W'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      txn($sformatf("rand%0d", t), ra, rb, model_d(ra, rb), model_bout(ra, rb),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
